// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_PRESSED,
        ST_REL_DB
    } state_e;

    typedef enum logic [1:0] {
        SW_NONE,
        SW_ONE,
        SW_MULTI
    } sweep_e;

    // Hex value per sample bit; bit index = col*4 + row, row 0 is the top row.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // col 3, rows 3..0
        4'hE, 4'h9, 4'h6, 4'h3,   // col 2
        4'hF, 4'h8, 4'h5, 4'h2,   // col 1
        4'h0, 4'h7, 4'h4, 4'h1    // col 0
    };

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_sweep.sv
// Column scanner: synchronizes rows, walks the active-low column one-hot,
// captures one 4-bit row sample per column and decodes each full sweep.
module keypad_sweep
    import keypad_pkg::*;
#(
    parameter int DWELL = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       sweep_done_o,
    output sweep_e     result_o,
    output logic [3:0] code_o
);
    localparam int DW = $clog2(DWELL);

    logic [3:0]    sync1_q, sync2_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    col_q;
    logic [11:0]   samp_q;   // pressed flags for columns 0..2
    logic          tick;
    logic [15:0]   sweep_vec;
    logic [4:0]    n_low;
    logic [3:0]    idx;

    assign tick         = (dwell_q == DW'(DWELL - 1));
    assign sweep_done_o = tick && (col_q == 2'd3);
    assign col_o        = ~(4'b0001 << col_q);
    // Column 3 is taken live on the closing tick so the decode sees all 16 samples.
    assign sweep_vec    = {~sync2_q, samp_q};

    // Row synchronizer, dwell counter, column index and per-column sample capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            dwell_q <= '0;
            col_q   <= 2'd0;
            samp_q  <= '0;
        end else begin
            sync1_q <= row_i;
            sync2_q <= sync1_q;
            dwell_q <= tick ? '0 : dwell_q + DW'(1);
            if (tick) begin
                col_q <= col_q + 2'd1;
                case (col_q)
                    2'd0:    samp_q[3:0]  <= ~sync2_q;
                    2'd1:    samp_q[7:4]  <= ~sync2_q;
                    2'd2:    samp_q[11:8] <= ~sync2_q;
                    default: ;
                endcase
            end
        end
    end

    // Count pressed samples and remember which one; only meaningful for one press.
    always_comb begin
        n_low = 5'd0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (sweep_vec[i]) begin
                n_low = n_low + 5'd1;
                idx   = i[3:0];
            end
        end
        result_o = (n_low == 5'd0) ? SW_NONE : (n_low == 5'd1) ? SW_ONE : SW_MULTI;
        code_o   = KEY_MAP[idx];
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad reader: sweep-level debounce FSM, valid/ack report handshake
// and sticky overrun flag. Define KEYPAD_AUTOREPEAT_EN to add auto-repeat
// while a key stays held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int SCAN_HZ         = 1000,
    parameter int DEBOUNCE_SWEEPS = 4,
    parameter int REPEAT_SWEEPS   = 250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_ACK,
    output logic       KEY_HELD,
    output logic       OVERRUN
);
    localparam int DWELL   = CLK_HZ / SCAN_HZ;
    localparam int CNT_MAX = imax(DEBOUNCE_SWEEPS, REPEAT_SWEEPS);
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic       sweep_done;
    sweep_e     res;
    logic [3:0] code;

    state_e        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          report;
    logic [3:0]    code_q;
    logic          valid_q, ovr_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SWEEPS + 1);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    keypad_sweep #(.DWELL(DWELL)) u_sweep (
        .clk_i        (CLK),
        .rst_i        (RST),
        .row_i        (ROW),
        .col_o        (COL),
        .sweep_done_o (sweep_done),
        .result_o     (res),
        .code_o       (code)
    );

    assign cnt_inc   = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
    assign KEY_CODE  = code_q;
    assign KEY_VALID = valid_q;
    assign OVERRUN   = ovr_q;
    assign KEY_HELD  = (state_q == ST_PRESSED) || (state_q == ST_REL_DB);

    // Debounce FSM; moves only on sweep boundaries, MULTI never changes counters.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        report  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (sweep_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (res == SW_ONE) begin
                        cand_d = code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SWEEPS <= 1) begin
                            state_d = ST_PRESSED;
                            report  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rpt_d   = '0;
`endif
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (res == SW_ONE) begin
                        if (code == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= CW'(DEBOUNCE_SWEEPS)) begin
                                state_d = ST_PRESSED;
                                report  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rpt_d   = '0;
`endif
                            end
                        end else begin
                            cand_d = code;
                            cnt_d  = CW'(1);
                        end
                    end else if (res == SW_NONE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (res == SW_NONE) begin
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE_SWEEPS <= 1) ? ST_IDLE : ST_REL_DB;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rpt_q >= RW'(REPEAT_SWEEPS - 1)) begin
                            rpt_d  = '0;
                            report = 1'b1;
                        end else begin
                            rpt_d  = rpt_q + RW'(1);
                        end
`endif
                    end
                end
                ST_REL_DB: begin
                    if (res == SW_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CW'(DEBOUNCE_SWEEPS)) state_d = ST_IDLE;
                    end else if (res == SW_ONE && code == cand_q) begin
                        state_d = ST_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers plus report/ack handshake; a report beats a same-cycle ack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
            if (report) begin
                code_q  <= cand_d;
                valid_q <= 1'b1;
                if (valid_q && !KEY_ACK) ovr_q <= 1'b1;
            end else if (valid_q && KEY_ACK) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: DWELL=10 (40-cycle sweeps), 3-sweep debounce.
// The keypad is modelled as a switch matrix pulling ROW low through the driven COL.
module tb_keypad_scan;
    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEY_CODE;
    logic       KEY_VALID;
    logic       KEY_ACK;
    logic       KEY_HELD;
    logic       OVERRUN;

    keypad_scan #(
        .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_SWEEPS(3), .REPEAT_SWEEPS(5)
    ) dut (
        .CLK(CLK), .RST(RST), .ROW(ROW), .COL(COL), .KEY_CODE(KEY_CODE),
        .KEY_VALID(KEY_VALID), .KEY_ACK(KEY_ACK), .KEY_HELD(KEY_HELD), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Key bit = col*4 + row.
    localparam logic [15:0] K1 = 16'h0001, K4 = 16'h0002, K7 = 16'h0004, K0 = 16'h0008;
    localparam logic [15:0] K2 = 16'h0010, K5 = 16'h0020, K8 = 16'h0040, KF = 16'h0080;
    localparam logic [15:0] K3 = 16'h0100, K6 = 16'h0200, K9 = 16'h0400, KE = 16'h0800;
    localparam logic [15:0] KA = 16'h1000, KB = 16'h2000, KC = 16'h4000, KD = 16'h8000;

    logic [15:0] keys = 16'h0;

    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4 + r] && !COL[c]) ROW[r] = 1'b0;
    end

    int rises = 0;
    logic vprev = 1'b0;
    always @(negedge CLK) begin
        if (KEY_VALID && !vprev) rises++;
        vprev = KEY_VALID;
    end

    typedef struct {
        logic [15:0] keys;
        int          sweeps;
        logic        ack;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_held;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs [23];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic ack_pulse();
        KEY_ACK = 1'b1;
        tick(1);
        KEY_ACK = 1'b0;
        chk("ack_valid", KEY_VALID, 1'b0);
        chk("ack_ovr", OVERRUN, 1'b0);
    endtask

    initial begin
        int sw;
        int base;
        int rbase;

        vecs[0]  = '{16'h0,   1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{K5,      2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[2]  = '{K5,      1, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0};
        vecs[3]  = '{K5,      2, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0};
        vecs[4]  = '{16'h0,   2, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0};
        vecs[5]  = '{16'h0,   1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
        vecs[6]  = '{K1 | K2, 4, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
        vecs[7]  = '{16'h0,   1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
        vecs[8]  = '{KA,      3, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0};
        vecs[9]  = '{KA | KB, 4, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0};
        vecs[10] = '{16'h0,   3, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0};
        vecs[11] = '{K3,      3, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0};
        vecs[12] = '{16'h0,   3, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0};
        vecs[13] = '{KD,      3, 1'b1, 1'b1, 4'hD, 1'b1, 1'b1};
        vecs[14] = '{16'h0,   3, 1'b0, 1'b0, 4'hD, 1'b0, 1'b0};
        vecs[15] = '{K7,      3, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0};
        vecs[16] = '{16'h0,   1, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0};
        vecs[17] = '{K7,      2, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0};
        vecs[18] = '{16'h0,   3, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0};
        vecs[19] = '{K4,      2, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0};
        vecs[20] = '{K6,      2, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0};
        vecs[21] = '{K6,      1, 1'b1, 1'b1, 4'h6, 1'b1, 1'b0};
        vecs[22] = '{16'h0,   3, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0};

        // Reset
        RST = 1'b1;
        KEY_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_col", COL, 4'b1110);
        chk("rst_code", KEY_CODE, 4'h0);
        chk("rst_valid", KEY_VALID, 1'b0);
        chk("rst_held", KEY_HELD, 1'b0);
        chk("rst_ovr", OVERRUN, 1'b0);
        RST = 1'b0;
        cyc = 0;
        tick(9);
        chk("col_dwell", COL, 4'b1110);
        tick(1);
        chk("col_adv", COL, 4'b1101);

        // Table: each entry holds keys for whole sweeps, then checks outputs.
        sw = 0;
        for (int i = 0; i < 23; i++) begin
            keys = vecs[i].keys;
            sw += vecs[i].sweeps;
            wait_to(sw * 40);
            chk($sformatf("v%0d_valid", i), KEY_VALID, vecs[i].exp_valid);
            chk($sformatf("v%0d_code", i), KEY_CODE, vecs[i].exp_code);
            chk($sformatf("v%0d_held", i), KEY_HELD, vecs[i].exp_held);
            chk($sformatf("v%0d_ovr", i), OVERRUN, vecs[i].exp_ovr);
            if (vecs[i].ack) ack_pulse();
        end

        // Bounce on "9": sweep 1 sees it, sweep 2 does not, then stays down.
        base  = sw * 40;
        rbase = rises;
        for (int t = 0; t < 80; t++) begin
            keys = ((t / 15) % 2 == 1) ? K9 : 16'h0;
            tick(1);
        end
        keys = K9;
        wait_to(base + 160);
        chk("bounce_early", KEY_VALID, 1'b0);
        wait_to(base + 200);
        chk("bounce_valid", KEY_VALID, 1'b1);
        chk("bounce_code", KEY_CODE, 4'h9);
        ack_pulse();
        chk("bounce_reports", 4'(rises - rbase), 4'd1);
        keys = 16'h0;
        wait_to(base + 320);
        chk("bounce_rel", KEY_HELD, 1'b0);

        // Report coincident with ACK while a previous code is still pending.
        base = base + 320;
        keys = KE;
        wait_to(base + 120);
        chk("co_e_valid", KEY_VALID, 1'b1);
        chk("co_e_code", KEY_CODE, 4'hE);
        keys = 16'h0;
        wait_to(base + 240);
        chk("co_rel", KEY_HELD, 1'b0);
        keys = K0;
        wait_to(base + 359);
        chk("co_pre_code", KEY_CODE, 4'hE);
        KEY_ACK = 1'b1;
        tick(1);
        KEY_ACK = 1'b0;
        chk("co_valid", KEY_VALID, 1'b1);
        chk("co_code", KEY_CODE, 4'h0);
        chk("co_ovr", OVERRUN, 1'b0);
        ack_pulse();
        keys = 16'h0;
        wait_to(base + 480);
        chk("co_held", KEY_HELD, 1'b0);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Auto-repeat on "F": first report at debounce, then every 5 sweeps.
        base = base + 480;
        keys = KF;
        wait_to(base + 120);
        chk("rpt0_valid", KEY_VALID, 1'b1);
        chk("rpt0_code", KEY_CODE, 4'hF);
        ack_pulse();
        wait_to(base + 319);
        chk("rpt1_early", KEY_VALID, 1'b0);
        tick(1);
        chk("rpt1_valid", KEY_VALID, 1'b1);
        chk("rpt1_code", KEY_CODE, 4'hF);
        ack_pulse();
        wait_to(base + 520);
        chk("rpt2_valid", KEY_VALID, 1'b1);
        chk("rpt2_code", KEY_CODE, 4'hF);
        ack_pulse();
        keys = 16'h0;
        wait_to(base + 640);
        chk("rpt_rel", KEY_HELD, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
